// File: rtl/instr_fetch.sv
// Two-stage instruction fetch front end: a request register tracks the
// address sent to instruction memory, an output register captures the
// returned instruction together with the address it came from. A small
// IDLE/RUN/HALT controller gates the PC stage and stops on HALT_OP.
//
// Handshake: instr_valid is a one-cycle qualifier for instr/instr_pc.
// There is no backpressure; decode must accept every valid cycle.
// redirect squashes both in-flight slots in the cycle it is asserted.
module instr_fetch #(
  parameter int          D       = 12,
  parameter int          W       = 9,
  parameter logic [W-1:0] HALT_OP = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] prog_ctr,
  input  logic         redirect,
  output logic [D-1:0] imem_addr,
  input  logic [W-1:0] imem_rdata,
  output logic         pc_run,
  output logic [W-1:0] instr,
  output logic [D-1:0] instr_pc,
  output logic         instr_valid,
  output logic         done,
  output logic [15:0]  icount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         req_v_q, req_v_d;
  logic [D-1:0] req_pc_q, req_pc_d;
  logic [W-1:0] instr_q, instr_d;
  logic [D-1:0] instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         done_q, done_d;
  logic [15:0]  icount_q, icount_d;

  logic in_run;
  logic in_halt;

  assign in_run  = (state_q == RUN);
  assign in_halt = (state_q == HALT);

  // Next-state logic: start launches a run from IDLE or HALT; a valid
  // HALT_OP reaching stage 2 ends the run (a squashed one does not).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (instr_valid_d && (imem_rdata == HALT_OP)) state_d = HALT;
      HALT: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Pipeline datapath, done flag and delivered-instruction counter.
  always_comb begin
    req_v_d       = in_run & ~redirect;
    req_pc_d      = prog_ctr;
    instr_valid_d = req_v_q & ~redirect & in_run;
    // Once halted the last delivered instruction stays visible.
    instr_d       = in_halt ? instr_q    : imem_rdata;
    instr_pc_d    = in_halt ? instr_pc_q : req_pc_q;
    done_d        = (state_d == HALT);
    icount_d      = icount_q;
    if (!in_run && (state_d == RUN)) begin
      icount_d = 16'd0;
    end else if (instr_valid_d && (icount_q != 16'hFFFF)) begin
      icount_d = icount_q + 16'd1;
    end
  end

  // State and pipeline registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      req_v_q       <= 1'b0;
      req_pc_q      <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
      icount_q      <= 16'd0;
    end else begin
      state_q       <= state_d;
      req_v_q       <= req_v_d;
      req_pc_q      <= req_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
      icount_q      <= icount_d;
    end
  end

  assign imem_addr   = prog_ctr;
  assign pc_run      = in_run;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign done        = done_q;
  assign icount      = icount_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: synchronous-read memory model, per-scenario
// tasks, and an expected-{pc,instr} queue drained whenever instr_valid is seen.
module tb_instr_fetch;

  localparam int D = 12;
  localparam int W = 9;
  localparam logic [W-1:0] HALT = {W{1'b1}};
  localparam int R = 200;

  // Clock / reset block
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [D-1:0] prog_ctr = '0;
  logic         redirect = 1'b0;
  logic [D-1:0] imem_addr;
  logic [W-1:0] imem_rdata;
  logic         pc_run;
  logic [W-1:0] instr;
  logic [D-1:0] instr_pc;
  logic         instr_valid;
  logic         done;
  logic [15:0]  icount;

  logic [W-1:0]     mem [0:(1<<D)-1];
  logic [D+W-1:0]   exp_q [$];
  int checks = 0;
  int failures = 0;

  instr_fetch #(.D(D), .W(W), .HALT_OP(HALT)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_ctr(prog_ctr),
    .redirect(redirect), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_run(pc_run), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .done(done), .icount(icount)
  );

  // Instruction memory: data one cycle after the address.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  // Driver: present inputs for one cycle, then sample that cycle's outputs
  // on the falling edge and retire any delivered instruction.
  task automatic step(input logic [D-1:0] pc, input logic redir, input logic st);
    logic [D+W-1:0] exp;
    @(posedge clk); #1;
    prog_ctr = pc; redirect = redir; start = st;
    @(negedge clk);
    if (instr_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got pc=%h instr=%h exp=none", instr_pc, instr);
      end else begin
        exp = exp_q.pop_front();
        if ({instr_pc, instr} !== exp) begin
          failures++;
          $display("FAIL sb_data got pc=%h instr=%h exp pc=%h instr=%h",
                   instr_pc, instr, exp[D+W-1:W], exp[W-1:0]);
        end
      end
    end
  endtask

  task automatic push_exp(input logic [D-1:0] pc);
    exp_q.push_back({pc, mem[pc]});
  endtask

  // Called right after a falling-edge sample: reset lands before the next rise.
  task automatic apply_reset();
    #2 reset = 1'b1;
    redirect = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if ({instr_valid, done, pc_run, icount, instr, instr_pc} !== '0) begin
      failures++; $display("FAIL reset_outputs got v=%b d=%b r=%b ic=%h i=%h pc=%h exp all 0",
                           instr_valid, done, pc_run, icount, instr, instr_pc); end
    prog_ctr = D'($urandom_range(0, (1<<D)-1));
    #1;
    checks++; if (imem_addr !== prog_ctr) begin
      failures++; $display("FAIL imem_addr got=%h exp=%h", imem_addr, prog_ctr); end
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(D'(k + 7), 1'b0, 1'b0);
      checks++; if ({pc_run, instr_valid, done} !== 3'b000) begin
        failures++; $display("FAIL idle_hold got run=%b v=%b d=%b exp 000", pc_run, instr_valid, done); end
    end
  endtask

  task automatic test_basic();
    step('0, 1'b0, 1'b1);
    for (int k = 0; k <= 21; k++) begin
      step(D'(k), 1'b0, (k == 10));
      if (k < 20) push_exp(D'(k));
      if (k < 2) begin
        checks++; if (instr_valid !== 1'b0) begin
          failures++; $display("FAIL basic_latency c%0d got v=%b exp 0", k, instr_valid); end
      end else begin
        checks++; if (instr_valid !== 1'b1) begin
          failures++; $display("FAIL basic_stream c%0d got v=%b exp 1", k, instr_valid); end
      end
      if (k == 2) begin
        checks++; if ({instr_pc, instr} !== {D'(0), W'(1)}) begin
          failures++; $display("FAIL basic_first got pc=%h i=%h exp pc=0 i=1", instr_pc, instr); end
      end
      if (k == 3) begin
        checks++; if ({pc_run, imem_addr} !== {1'b1, D'(3)}) begin
          failures++; $display("FAIL basic_run got run=%b addr=%h exp 1 003", pc_run, imem_addr); end
      end
    end
    checks++; if (icount !== 16'd20) begin
      failures++; $display("FAIL basic_icount got=%0d exp=20", icount); end
    checks++; if (exp_q.size() != 0) begin
      failures++; $display("FAIL basic_drain got=%0d exp=0", exp_q.size()); end
    apply_reset();
    step('0, 1'b0, 1'b0);
    checks++; if ({instr_valid, pc_run} !== 2'b00) begin
      failures++; $display("FAIL post_reset got v=%b run=%b exp 00", instr_valid, pc_run); end
  endtask

  task automatic test_redirect();
    step('0, 1'b0, 1'b1);
    for (int k = 0; k <= 13; k++) begin
      step((k < 6) ? D'(k) : D'(100 + k - 6), (k == 5), 1'b0);
      if (k < 12 && k != 4 && k != 5) push_exp((k < 6) ? D'(k) : D'(100 + k - 6));
      if (k == 6 || k == 7) begin
        checks++; if (instr_valid !== 1'b0) begin
          failures++; $display("FAIL redirect_squash c%0d got v=%b exp 0", k, instr_valid); end
      end
      if (k == 8) begin
        checks++; if ({instr_valid, instr_pc} !== {1'b1, D'(100)}) begin
          failures++; $display("FAIL redirect_resume got v=%b pc=%h exp 1 064", instr_valid, instr_pc); end
      end
    end
    checks++; if (exp_q.size() != 0) begin
      failures++; $display("FAIL redirect_drain got=%0d exp=0", exp_q.size()); end
    apply_reset();
  endtask

  task automatic test_halt();
    mem[4] = HALT;
    step('0, 1'b0, 1'b1);
    for (int k = 0; k <= 8; k++) begin
      step(D'(k), 1'b0, 1'b0);
      if (k <= 4) push_exp(D'(k));
      if (k == 6) begin
        checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, HALT, D'(4)}) begin
          failures++; $display("FAIL halt_deliver got v=%b i=%h pc=%h exp 1 %h 004", instr_valid, instr, instr_pc, HALT); end
      end
      if (k >= 7) begin
        checks++; if ({done, pc_run, instr_valid, instr, instr_pc} !== {3'b100, HALT, D'(4)}) begin
          failures++; $display("FAIL halt_state c%0d got d=%b r=%b v=%b i=%h pc=%h exp 1 0 0 %h 004",
                               k, done, pc_run, instr_valid, instr, instr_pc, HALT); end
        checks++; if (icount !== 16'd5) begin
          failures++; $display("FAIL halt_icount got=%0d exp=5", icount); end
      end
    end
    mem[4] = W'(5);
    step(D'(9), 1'b0, 1'b1);
    for (int k = 10; k <= 17; k++) begin
      step(D'(20 + k - 10), 1'b0, 1'b0);
      if (k <= 15) push_exp(D'(20 + k - 10));
      if (k == 10) begin
        checks++; if ({pc_run, done, icount} !== {2'b10, 16'd0}) begin
          failures++; $display("FAIL restart got r=%b d=%b ic=%0d exp 1 0 0", pc_run, done, icount); end
      end
    end
    checks++; if (icount !== 16'd6) begin
      failures++; $display("FAIL restart_icount got=%0d exp=6", icount); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({instr_valid, done, pc_run, icount, instr, instr_pc} !== '0) begin
      failures++; $display("FAIL async_reset got v=%b d=%b r=%b ic=%h i=%h pc=%h exp all 0",
                           instr_valid, done, pc_run, icount, instr, instr_pc); end
    checks++; if (exp_q.size() != 0) begin
      failures++; $display("FAIL halt_drain got=%0d exp=0", exp_q.size()); end
    @(negedge clk); reset = 1'b0;
    step('0, 1'b0, 1'b0);
    checks++; if ({instr_valid, pc_run} !== 2'b00) begin
      failures++; $display("FAIL reset_release got v=%b run=%b exp 00", instr_valid, pc_run); end
  endtask

  task automatic test_halt_redirect();
    mem[4] = HALT;
    step('0, 1'b0, 1'b1);
    for (int k = 0; k <= 9; k++) begin
      step((k < 6) ? D'(k) : D'(200 + k - 6), (k == 5), 1'b0);
      if (k <= 3 || k == 6 || k == 7) push_exp((k < 6) ? D'(k) : D'(200 + k - 6));
      if (k == 6 || k == 7) begin
        checks++; if ({instr_valid, pc_run, done} !== 3'b010) begin
          failures++; $display("FAIL halt_squash c%0d got v=%b r=%b d=%b exp 0 1 0", k, instr_valid, pc_run, done); end
      end
    end
    mem[4] = W'(5);
    checks++; if (exp_q.size() != 0) begin
      failures++; $display("FAIL halt_squash_drain got=%0d exp=0", exp_q.size()); end
    apply_reset();
  endtask

  task automatic test_random();
    logic         redir_a [0:R+1];
    logic [D-1:0] pc_a    [0:R+1];
    int n_push = 0;
    for (int k = 0; k <= R + 1; k++) begin
      redir_a[k] = ($urandom_range(0, 4) == 0);
      pc_a[k]    = D'($urandom_range(0, (1<<D)-1));
    end
    step('0, 1'b0, 1'b1);
    for (int k = 0; k <= R + 1; k++) begin
      step(pc_a[k], redir_a[k], ($urandom_range(0, 9) == 0));
      if (k < R && !redir_a[k] && !redir_a[k+1]) begin
        push_exp(pc_a[k]);
        n_push++;
      end
    end
    checks++; if (icount !== 16'(n_push)) begin
      failures++; $display("FAIL random_icount got=%0d exp=%0d", icount, n_push); end
    checks++; if (exp_q.size() != 0) begin
      failures++; $display("FAIL random_drain got=%0d exp=0", exp_q.size()); end
    apply_reset();
  endtask

  task automatic test_saturation();
    step('0, 1'b0, 1'b1);
    for (int k = 0; k <= 65537; k++) begin
      step(D'(k), 1'b0, 1'b0);
      if (k <= 65535) push_exp(D'(k));
      if (k == 65535) begin
        checks++; if (icount !== 16'hFFFE) begin
          failures++; $display("FAIL sat_before got=%h exp=fffe", icount); end
      end
      if (k >= 65536) begin
        checks++; if ({instr_valid, icount} !== {1'b1, 16'hFFFF}) begin
          failures++; $display("FAIL sat_hold c%0d got v=%b ic=%h exp 1 ffff", k, instr_valid, icount); end
      end
    end
    checks++; if (exp_q.size() != 0) begin
      failures++; $display("FAIL sat_drain got=%0d exp=0", exp_q.size()); end
    apply_reset();
  endtask

  initial begin
    for (int i = 0; i < (1<<D); i++) mem[i] = W'((i % 500) + 1);
    test_reset();
    test_basic();
    test_redirect();
    test_halt();
    test_halt_redirect();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter D, default 12: program-counter width, matching the PC stage.
REQ-002 Parameter W, default 9: instruction width.
REQ-003 Parameter HALT_OP, default all-ones (W bits): encoding that terminates the program.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a program run.
REQ-007 prog_ctr  input  D  current PC value from the PC stage.
REQ-008 redirect  input  1  taken branch or jump this cycle; squashes in-flight fetches.
REQ-009 imem_addr  output  D  instruction memory read address.
REQ-010 imem_rdata  input  W  instruction memory read data, valid one cycle after its address.
REQ-011 pc_run  output  1  high while the PC stage is allowed to advance.
REQ-012 instr  output  W  fetched instruction to decode.
REQ-013 instr_pc  output  D  address that instr was fetched from.
REQ-014 instr_valid  output  1  instr/instr_pc hold a live, non-squashed instruction.
REQ-015 done  output  1  program reached HALT_OP.
REQ-016 icount  output  16  count of valid instructions delivered in the current run.

Function
REQ-017 FSM states IDLE, RUN, HALT; pc_run = (state==RUN), combinational from state.
REQ-018 IDLE->RUN on start; start in RUN is ignored; HALT->RUN on start.
REQ-019 imem_addr = prog_ctr, combinational, in every state.
REQ-020 Stage-1 request register: each edge, req_v <= (state==RUN) & ~redirect and req_pc <= prog_ctr.
REQ-021 Stage-2 output register: each edge, instr <= imem_rdata, instr_pc <= req_pc, instr_valid <= req_v & ~redirect & (state==RUN).
REQ-022 Latency: address presented in cycle n gives instr_valid in cycle n+2, absent squash.
REQ-023 redirect in cycle n kills both in-flight slots: no instruction captured at the edge ending cycle n or at the following edge is valid.
REQ-024 RUN->HALT at the edge where stage 2 captures a valid instruction equal to HALT_OP; that HALT_OP is still delivered with instr_valid=1 for one cycle.
REQ-025 In HALT: req_v and instr_valid are forced to 0 from the next edge on; instr and instr_pc hold their last values.
REQ-026 If redirect coincides with a HALT_OP capture, redirect wins: the instruction is squashed and the state stays RUN.
REQ-027 done is registered: 1 exactly while state==HALT; cleared on the edge that leaves HALT.
REQ-028 icount increments by 1 on each edge that sets instr_valid=1, including HALT_OP.
REQ-029 icount saturates at 16'hFFFF; it does not wrap.
REQ-030 icount clears to 0 on the edge that enters RUN from IDLE or from HALT.
REQ-031 PC wrap-around is transparent: instr_pc carries the D-bit value unmodified.

Reset
REQ-032 reset asserted, asynchronously: state=IDLE, req_v=0, req_pc=0, instr=0, instr_pc=0, instr_valid=0, done=0, icount=0.
REQ-033 Reset asserted during RUN or HALT discards all in-flight fetches; no valid output in the cycle after release.
REQ-034 After reset release the block stays in IDLE, with pc_run=0, until start.

Verification
REQ-035 Reset, start at cycle 0, prog_ctr 0,1,2,... with imem[i]=i+1 -> instr_valid first high cycle 2 with instr=1, instr_pc=0; afterwards one instruction per cycle.
REQ-036 redirect pulsed in cycle 5 -> instr_valid=0 in cycles 6 and 7; valid resumes in cycle 8 with the post-redirect prog_ctr from cycle 6.
REQ-037 imem[4]=HALT_OP -> instr_valid with instr=HALT_OP in cycle 6; done=1 and pc_run=0 from cycle 7; icount=5; no further valids.
REQ-038 HALT_OP capture coinciding with redirect -> no valid output, state stays RUN, done stays 0.
REQ-039 Reset asserted mid-cycle during RUN -> all outputs zero immediately, without waiting for clk; start in HALT -> RUN with icount=0 and done=0 on the next edge.
REQ-040 icount preloaded near saturation via a long run (>=65536 valids) -> holds at 16'hFFFF and does not wrap.
